// File: rtl/fp8_accum.sv
// Accumulates a stream of FP8 E4M3 products into a signed Q.9 fixed-point sum.
// Define FP8_ACC_SAT_EN to saturate on overflow and report it on out_ovf; otherwise the sum wraps.
module fp8_accum #(
    parameter int EXP_BITS      = 4,
    parameter int MANTISSA_BITS = 3,
    parameter int BIAS          = 7,
    parameter int ACC_WIDTH     = 24,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam int FRAC_BITS = 9;
    // Left shift for exponent E is E - SHIFT_OFS, aligning the mantissa LSB to the Q.9 LSB.
    localparam int SHIFT_OFS = BIAS + MANTISSA_BITS - FRAC_BITS;
    localparam int NUM_EXP   = 2 ** EXP_BITS;
    localparam int MAG_W     = MANTISSA_BITS + NUM_EXP - SHIFT_OFS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   pipe_q, pipe_d;
    logic                   pipe_vld_q, pipe_vld_d;
    logic                   acc_clear;
    logic                   in_hs;

    logic                     prod_sign;
    logic [EXP_BITS-1:0]      prod_exp;
    logic [MANTISSA_BITS-1:0] prod_mant;
    logic [MAG_W-1:0]         mag_tbl [NUM_EXP];
    logic [MAG_W-1:0]         prod_mag;
    logic [ACC_WIDTH-1:0]     prod_mag_ext;
    logic [ACC_WIDTH-1:0]     prod_val;

    assign in_hs = in_valid & in_ready;

    // ---------------- FSM ----------------
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        acc_clear = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    rem_d     = len;
                    acc_clear = 1'b1;
                    state_d   = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- FP8 -> Q.9 conversion ----------------
    assign prod_sign = in_data[7];
    assign prod_exp  = in_data[MANTISSA_BITS +: EXP_BITS];
    assign prod_mant = in_data[MANTISSA_BITS-1:0];

    // One pre-shifted candidate per exponent; subnormals share the scale of E=1 without the hidden bit.
    generate
        for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_mag
            localparam int   SH  = ((gi == 0) ? 1 : gi) - SHIFT_OFS;
            localparam logic HID = (gi != 0);
            assign mag_tbl[gi] = MAG_W'({HID, prod_mant}) << SH;
        end
    endgenerate

    assign prod_mag     = mag_tbl[prod_exp];
    assign prod_mag_ext = ACC_WIDTH'(prod_mag);
    assign prod_val     = prod_sign ? (~prod_mag_ext + 1'b1) : prod_mag_ext;

    always_comb begin
        pipe_vld_d = in_hs;
        pipe_d     = in_hs ? prod_val : pipe_q;
    end

    // ---------------- Accumulator ----------------
`ifdef FP8_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic             ovf_q, ovf_d;
    logic [ACC_WIDTH:0] sum_ext;

    assign sum_ext = {acc_q[ACC_WIDTH-1], acc_q} + {pipe_q[ACC_WIDTH-1], pipe_q};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (acc_clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (pipe_vld_q) begin
            // The two top bits of the widened sum disagree exactly when the signed add overflowed.
            if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
                acc_d = sum_ext[ACC_WIDTH] ? SMIN : SMAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (acc_clear) begin
            acc_d = '0;
        end else if (pipe_vld_q) begin
            acc_d = acc_q + pipe_q;
        end
    end

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            acc_q      <= '0;
            pipe_q     <= '0;
            pipe_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            pipe_q     <= pipe_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    assign out_data = acc_q;

endmodule

// File: tb/tb_fp8_accum.sv
// Directed self-checking bench for fp8_accum; expected sums are hand-computed Q.9 values.
// Expectations for the long overflow run follow FP8_ACC_SAT_EN.
module tb_fp8_accum;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] vec [0:63];

    fp8_accum dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One accumulation of n products from vec[], optionally holding DONE with distractions for 'hold' cycles.
    task automatic do_run(input string tag, input int n, input logic [23:0] exp_data,
                          input logic exp_ovf, input int hold);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            if (i == 0) check({tag, "_rdy"}, 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            start    = 1'b1;
            len      = 8'd5;
            in_valid = 1'b1;
            in_data  = 8'h38;
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp_data));
            check({tag, "_hold_ovf"}, 32'(out_ovf), 32'(exp_ovf));
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        $display("run %s len=%0d out_data=0x%06h out_ovf=%0d", tag, n, out_data, out_ovf);
    endtask

    initial begin
        logic [23:0] big_data;
        logic        big_ovf;
`ifdef FP8_ACC_SAT_EN
        big_data = 24'h7FFFFF;
        big_ovf  = 1'b1;
`else
        big_data = 24'h960000;
        big_ovf  = 1'b0;
`endif
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;

        // 1.0 + 1.0 = 2.0
        vec[0] = 8'h38; vec[1] = 8'h38;
        do_run("two_ones", 2, 24'h000400, 1'b0, 0);

        // 1.0 - 1.0 + 2^-9
        vec[0] = 8'h38; vec[1] = 8'hB8; vec[2] = 8'h01;
        do_run("cancel_sub", 3, 24'h000001, 1'b0, 0);

        // largest code, 480.0
        vec[0] = 8'h7F;
        do_run("max_code", 1, 24'h03C000, 1'b0, 0);

        // both zero encodings
        vec[0] = 8'h80; vec[1] = 8'h00;
        do_run("zeros", 2, 24'h000000, 1'b0, 0);

        // -2.0 + 2^-6 = -1016 LSBs
        vec[0] = 8'hC0; vec[1] = 8'h08;
        do_run("neg_sum", 2, 24'hFFFC08, 1'b0, 0);

        // len = 0 goes straight to DONE
        start = 1'b1;
        len   = 8'd0;
        check("len0_start_rdy", 32'(in_ready), 32'd0);
        tick();
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_valid", 32'(out_valid), 32'd1);
        check("len0_data", 32'(out_data), 32'd0);
        check("len0_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("len0_idle", 32'(busy), 32'd0);
        $display("run len0 len=0 out_data=0x%06h out_ovf=%0d", out_data, out_ovf);

        // 40 x 480.0 overflows 24 bits; DONE is then held with start/in_valid noise
        for (int i = 0; i < 40; i++) vec[i] = 8'h7F;
        do_run("overflow", 40, big_data, big_ovf, 5);

        // reset in the middle of an accumulation
        start = 1'b1;
        len   = 8'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h38;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_pre_data", 32'(out_data), 32'h400);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ovf", 32'(out_ovf), 32'd0);
        tick();
        rst = 1'b0;
        $display("run mid_reset len=3 abandoned out_data=0x%06h", out_data);
        vec[0] = 8'h38;
        do_run("after_rst", 1, 24'h000200, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
